// File: rtl/ooo_queue_pkg.sv
// Shared queue defaults and the leading-ones counter used by the queue,
// rename and issue logic.
package ooo_pkg;

    localparam int unsigned QUEUE_WIDTH = 32;
    localparam int unsigned QUEUE_DEPTH = 16;
    localparam int unsigned MAX_LANES   = 8;

    // Counts consecutive ones from bit 0, looking at the low n bits only.
    function automatic int unsigned lead_ones_count(input logic [MAX_LANES-1:0] bits,
                                                    input int unsigned           n);
        int unsigned cnt;
        logic        run;
        cnt = 0;
        run = 1'b1;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (run && (i < n) && bits[i]) cnt = cnt + 1;
            else                           run = 1'b0;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ooo_queue_if.sv
// Producer/consumer handshake bundle of the multi-lane ooo_queue.
interface ooo_queue_if
    import ooo_pkg::*;
#(
    parameter int unsigned WIDTH  = QUEUE_WIDTH,
    parameter int unsigned DEPTH  = QUEUE_DEPTH,
    parameter int unsigned N_PUSH = 2,
    parameter int unsigned N_POP  = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [N_PUSH-1:0]            in_valid;
    logic [N_PUSH-1:0][WIDTH-1:0] in_data;
    logic [N_PUSH-1:0]            in_ready;
    logic [N_POP-1:0]             out_valid;
    logic [N_POP-1:0][WIDTH-1:0]  out_data;
    logic [N_POP-1:0]             out_ready;
    logic [CNT_W-1:0]             count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/ooo_queue_lead_ones.sv
// Number of consecutive set bits starting at bit 0 of an N-bit vector.
module lead_ones
    import ooo_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]             bits,
    output logic [$clog2(N+1)-1:0]   cnt
);
    localparam int unsigned CW = $clog2(N + 1);

    logic [MAX_LANES-1:0] padded;

    always_comb begin
        padded        = '0;
        padded[N-1:0] = bits;
        cnt           = CW'(lead_ones_count(padded, N));
    end

endmodule

// File: rtl/ooo_queue.sv
// Multi-lane circular FIFO with per-lane handshakes and synchronous flush.
// Define OOO_QUEUE_FLUSH_CLEAR_EN to make flush also zero the entry array.
module ooo_queue
    import ooo_pkg::*;
#(
    parameter int unsigned WIDTH  = QUEUE_WIDTH,
    parameter int unsigned DEPTH  = QUEUE_DEPTH,
    parameter int unsigned N_PUSH = 2,
    parameter int unsigned N_POP  = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    ooo_queue_if.slave q
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(N_PUSH + 1);
    localparam int unsigned QW = $clog2(N_POP + 1);

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;

    addr_t            head_q, head_d, tail_q, tail_d;
    cnt_t             count_q, count_d, free_slots;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [N_PUSH-1:0] push_ok;
    logic [N_POP-1:0]  pop_ok;
    logic [PW-1:0]     push_raw, push_n;
    logic [QW-1:0]     pop_raw, pop_n;

    // Handshake outputs come from registered count only, so in_ready never
    // depends on out_ready and a full queue refuses pushes even while popping.
    always_comb begin
        free_slots = cnt_t'(DEPTH) - count_q;
        for (int unsigned i = 0; i < N_PUSH; i++) begin
            q.in_ready[i] = free_slots > cnt_t'(i);
        end
        for (int unsigned j = 0; j < N_POP; j++) begin
            q.out_valid[j] = count_q > cnt_t'(j);
            q.out_data[j]  = mem_q[head_q + addr_t'(j)];
        end
    end

    assign q.count = count_q;
    assign push_ok = q.in_valid & q.in_ready;
    assign pop_ok  = q.out_valid & q.out_ready;

    lead_ones #(.N(N_PUSH)) u_push_cnt (.bits(push_ok), .cnt(push_raw));
    lead_ones #(.N(N_POP))  u_pop_cnt  (.bits(pop_ok),  .cnt(pop_raw));

    always_comb begin
        push_n  = flush ? '0 : push_raw;
        pop_n   = flush ? '0 : pop_raw;
        head_d  = flush ? '0 : head_q + addr_t'(pop_n);
        tail_d  = flush ? '0 : tail_q + addr_t'(push_n);
        count_d = flush ? '0 : count_q + cnt_t'(push_n) - cnt_t'(pop_n);
        mem_d   = mem_q;
        for (int unsigned i = 0; i < N_PUSH; i++) begin
            if (PW'(i) < push_n) mem_d[tail_q + addr_t'(i)] = q.in_data[i];
        end
`ifdef OOO_QUEUE_FLUSH_CLEAR_EN
        if (flush) begin
            for (int unsigned k = 0; k < DEPTH; k++) mem_d[k] = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: doc/ooo_queue.md
# ooo_queue

Multi-lane circular FIFO between fetch and decode in the out-of-order core; also reused as the instruction-buffer template for later stages. Accepts up to N_PUSH words per cycle from the producer and presents the oldest N_POP words to the consumer, with per-lane valid/ready handshakes and a synchronous flush for mispredict recovery. Storage is a flip-flop array indexed by internal head/tail pointers.

## Interface
- WIDTH, 32, payload width in bits
- DEPTH, 16, entry count; power of two, at least max(N_PUSH, N_POP)
- N_PUSH, 2, enqueue lanes per cycle
- N_POP, 2, dequeue lanes per cycle
- clk  in  1  clock, all state updates on posedge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush, discards all entries
- in_valid  in  N_PUSH  per-lane push request
- in_data  in  N_PUSH×WIDTH  push payload, lane 0 is oldest
- in_ready  out  N_PUSH  lane i may push this cycle
- out_valid  out  N_POP  lane j holds a valid entry
- out_data  out  N_POP×WIDTH  entry at head+j
- out_ready  in  N_POP  consumer takes lane j
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State: head, tail (ADDR_WIDTH = $clog2(DEPTH) bits, wrap naturally modulo DEPTH), count (ADDR_WIDTH+1 bits), entry array.
- in_ready[i] = (DEPTH − count) > i; depends only on registered count, never on out_ready.
- Push count P = number of leading lanes from 0 with in_valid & in_ready; lanes after the first gap are ignored, never written.
- Lane i of the accepted prefix writes entry tail+i; tail advances by P.
- out_valid[j] = count > j; out_data[j] = entry[head+j], read from registered state (no same-cycle push-to-pop bypass).
- Pop count Q = number of leading lanes with out_valid & out_ready; head advances by Q.
- count_next = count + P − Q; never exceeds DEPTH, never underflows, by construction.
- Full (count == DEPTH): all in_ready low even if the consumer pops this cycle.
- Empty: all out_valid low; out_data shows stale storage contents.
- flush: highest priority; P and Q forced to 0; next cycle head = tail = count = 0; out_valid all low, in_ready all high.

## Timing
- Reset (async assert): head = tail = count = 0, all entries 0; out_valid = 0, in_ready = all 1, out_data = 0, count = 0.
- Push-to-visible latency 1 cycle: word accepted at edge k appears on out_valid/out_data after edge k.
- Pop and push in the same cycle both take effect at the same edge.
- Reset deasserted mid-operation: state remains reset-valued; first push accepted on the first edge with resetn high.
- Pointer wrap: tail = DEPTH−1 with P = 2 writes entries DEPTH−1 and 0; tail becomes 1.

## Configuration
- OOO_QUEUE_FLUSH_CLEAR_EN defined: flush also zeroes every entry, so out_data reads 0 on the cycle after flush.
- Not defined: flush resets pointers and count only; entry contents are retained and out_data shows the old entry[0..N_POP−1].
- Handshake and count behaviour are identical in both builds.

## Structure
- Package ooo_pkg: default QUEUE_WIDTH and QUEUE_DEPTH constants; the leading-ones count function is shared with rename and issue logic.
- Module-local: addr_t and cnt_t, which depend on parameters.
- Sub-module lead_ones (parameter N): N-bit input, $clog2(N+1)-bit count of consecutive ones from bit 0. Instantiated twice, for P and Q.

## Test plan
- Reset, then idle: count = 0, in_ready = 2'b11, out_valid = 2'b00, out_data = 0.
- Push lanes 0,1 = 0xA, 0xB, no pop -> next cycle count = 2, out_valid = 2'b11, out_data = {0xB, 0xA}.
- in_valid = 2'b10 (gap at lane 0) -> nothing written; count unchanged.
- Fill to 15, push 2 while popping 1 -> only lane 0 accepted (in_ready = 2'b01); count = 15 next cycle.
- At count = 16, in_ready = 0 while out_ready = 2'b11 -> 2 popped, count = 14; wrap check: 40 pushes/pops of incrementing values emerge in order.
- flush with count = 5 plus simultaneous push/pop -> count = 0, out_valid = 0; out_data = 0 only when OOO_QUEUE_FLUSH_CLEAR_EN is defined.
